// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: op codes, FSM states, constants and op-decode helpers for the MEM-stage LSU
// Op code layout: [3] store, [2] zero-extend (loads), [1:0] log2 of access size in bytes.
package mem_lsu_pkg;
  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_LWU = 4'h6;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_SD  = 4'hB;
  localparam logic ZERO          = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic logic [1:0] op_size(input logic [3:0] op);
    return op[1:0];
  endfunction
  function automatic logic op_store(input logic [3:0] op);
    return op[3];
  endfunction
  function automatic logic op_unsigned(input logic [3:0] op);
    return op[2];
  endfunction
  // Doubleword accesses and LWU only exist on a 64-bit datapath.
  function automatic logic is_mem_op(input logic [3:0] op, input logic wide);
    return (op[3] ? ~op[2] : op != 4'h7) & (wide | (op[1:0] != 2'd3 & op != OP_LWU));
  endfunction
  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    return (addr_lo & ((3'd1 << size) - 3'd1)) != 3'd0;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: shifts bus read data down to the accessed byte and sign/zero-extends it
// rdata: raw bus word, offset: byte offset within the word, op: load op code, result: writeback value
module mem_load_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           rdata,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [3:0]                      op,
  output logic [DATA_WIDTH-1:0]           result
);
  logic [DATA_WIDTH-1:0] sh, mask;
  assign sh = rdata >> {offset, 3'b000};
  // Shifting by the full width yields zero, so a full-width access gets an all-ones mask.
  assign mask = ~({DATA_WIDTH{1'b1}} << (8 << op_size(op)));
  // mask ^ (mask >> 1) isolates the sign bit of the accessed field.
  assign result = (sh & mask) | ((~op_unsigned(op) & |(sh & (mask ^ (mask >> 1)))) ? ~mask : '0);
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a req/ack data bus, plus the MEM/WB register
// EX/MEM side: valid_i, reg_*_i, mem_addr_i, mem_data_i, mem_op_i; stall_o holds upstream.
// Bus side: bus_req_o/we/addr/wdata/be out, bus_ack_i/rdata/err in.
// WB side: wb_valid_o, reg_waddr_o, reg_we_o, reg_wdata_o; misalign_o/fault_o are one-cycle pulses.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int TIMEOUT     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
  input  logic                    reg_we_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_data_i,
  input  logic [3:0]              mem_op_i,
  output logic                    stall_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  input  logic                    bus_ack_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_err_i,
  output logic                    wb_valid_o,
  output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
  output logic                    reg_we_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic                    misalign_o,
  output logic                    fault_o
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t state, state_n;
  logic [3:0] op_q;
  logic [OFF_W-1:0] off_q;
  logic we_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0] size;
  logic mem_op, mis, go, ack, tmo;
  logic [BE_W-1:0] be;
  logic [DATA_WIDTH-1:0] wdata, ld_data;
  assign size   = op_size(mem_op_i);
  assign mem_op = valid_i & is_mem_op(mem_op_i, DATA_WIDTH == 64);
  assign mis    = mem_op & misaligned(mem_addr_i[2:0], size);
  assign go     = state == IDLE & mem_op & ~mis;
  assign ack    = state == BUSY & bus_ack_i;
  // An ack in the final allowed cycle takes priority over the timeout.
  assign tmo    = state == BUSY & ~bus_ack_i & (TIMEOUT != 0) & cnt == CNT_W'(TIMEOUT - 1);
  assign stall_o = go | (state == BUSY & ~bus_ack_i & ~tmo);
  assign be = ~({BE_W{1'b1}} << (1 << size)) << mem_addr_i[OFF_W-1:0];
  // Replicate the store datum across every lane so the slave can pick any lane by be.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < BE_W; i++) wdata[8*i+:8] = mem_data_i[8*(i % (1 << size))+:8];
  end
  always_comb begin
    state_n = state;
    if (go) state_n = BUSY;
    else if (ack | tmo) state_n = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata  (bus_rdata_i),
    .offset (off_q),
    .op     (op_q),
    .result (ld_data)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_req_o   <= ZERO;
      bus_we_o    <= ZERO;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
      wb_valid_o  <= ZERO;
      reg_waddr_o <= '0;
      reg_we_o    <= WRITE_DISABLE;
      reg_wdata_o <= '0;
      misalign_o  <= ZERO;
      fault_o     <= ZERO;
      op_q        <= '0;
      off_q       <= '0;
      we_q        <= WRITE_DISABLE;
      cnt         <= '0;
    end else if (state == IDLE) begin
      wb_valid_o  <= valid_i & ~go;
      reg_waddr_o <= reg_waddr_i;
      reg_we_o    <= valid_i & reg_we_i & ~mem_op;
      reg_wdata_o <= reg_wdata_i;
      misalign_o  <= mis;
      fault_o     <= ZERO;
      if (go) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= op_store(mem_op_i);
        bus_addr_o  <= mem_addr_i & ~ADDR_WIDTH'(BE_W - 1);
        bus_wdata_o <= wdata;
        bus_be_o    <= be;
        op_q        <= mem_op_i;
        off_q       <= mem_addr_i[OFF_W-1:0];
        we_q        <= reg_we_i;
        cnt         <= '0;
      end
    end else begin
      wb_valid_o  <= ack | tmo;
      reg_we_o    <= ack & ~bus_err_i & we_q & ~op_store(op_q);
      reg_wdata_o <= ld_data;
      misalign_o  <= ZERO;
      fault_o     <= tmo | (ack & bus_err_i);
      cnt         <= cnt + 1'b1;
      if (ack | tmo) bus_req_o <= 1'b0;
    end
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Parametrised, sequential successor to the combinational MEM stage, built as the MEM-stage load/store unit plus MEM/WB register.
- Drives a request/acknowledge data bus with byte enables, replacing read-modify-write merging of RAM read data.
- Handles multi-cycle memory latency by stalling the pipeline.
- Detects misaligned accesses, bus errors and bus timeouts.
- Supports 32- or 64-bit datapaths.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, datapath/register width; legal values 32 or 64 (64 enables LWU/LD/SD).
RADDR_WIDTH, 5, register index width.
TIMEOUT, 16, cycles to wait for bus_ack_i before faulting; 0 disables timeout.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
valid_i  in  1  EX/MEM holds a valid instruction.
reg_waddr_i  in  RADDR_WIDTH  destination register.
reg_we_i  in  1  register write enable.
reg_wdata_i  in  DATA_WIDTH  ALU result for non-memory ops.
mem_addr_i  in  ADDR_WIDTH  effective address.
mem_data_i  in  DATA_WIDTH  store data (low bits significant).
mem_op_i  in  4  memory op code (LB/LH/LW/LBU/LHU/LWU/LD/SB/SH/SW/SD, other = none).
stall_o  out  1  hold upstream pipeline (combinational).
bus_req_o  out  1  bus request, held until acknowledged.
bus_we_o  out  1  1 = write.
bus_addr_o  out  ADDR_WIDTH  address aligned down to DATA_WIDTH/8 bytes.
bus_wdata_o  out  DATA_WIDTH  lane-positioned store data.
bus_be_o  out  DATA_WIDTH/8  byte enables.
bus_ack_i  in  1  transfer complete; rdata/err valid this cycle.
bus_rdata_i  in  DATA_WIDTH  read data.
bus_err_i  in  1  bus error, qualified by bus_ack_i.
wb_valid_o  out  1  writeback bundle valid.
reg_waddr_o  out  RADDR_WIDTH  writeback register.
reg_we_o  out  1  writeback enable.
reg_wdata_o  out  DATA_WIDTH  writeback data.
misalign_o  out  1  one-cycle pulse, misaligned access.
fault_o  out  1  one-cycle pulse, bus error or timeout.

Behaviour:
- Reset (async):
  - State IDLE; all registered outputs 0.
  - A request in flight is abandoned: bus_req_o drops immediately, and the slave must tolerate this.
- FSM states: IDLE, BUSY.
- Op classification: memory op = valid_i & mem_op_i is a load/store code legal for DATA_WIDTH. LWU/LD/SD with DATA_WIDTH=32 count as non-memory.
- IDLE, non-memory op with valid_i:
  - Next edge: wb_valid_o=1, reg_* = inputs.
  - Latency 1, no stall.
- IDLE, valid_i=0: next edge wb_valid_o=0, reg_we_o=0.
- Misalignment, checked in IDLE:
  - H ops: addr[0]≠0. W ops: addr[1:0]≠0. D ops: addr[2:0]≠0.
  - Effect: no bus request, no stall. Next edge: misalign_o=1, wb_valid_o=1, reg_we_o=0.
- IDLE, aligned memory op:
  - stall_o=1 combinationally.
  - Next edge: state BUSY; bus_req_o=1; bus_we_o=store; bus_addr_o/bus_be_o/bus_wdata_o registered; op/offset/waddr latched.
- Byte enables (off = addr[log2(DATA_WIDTH/8)-1:0]):
  - B: 1<<off. H: 3<<off. W: 4'hF<<off. D: all ones.
  - Store data replicated across lanes (byte, halfword or word); unselected lanes are don't-care.
- BUSY:
  - stall_o = ~bus_ack_i.
  - bus_* outputs stable until the ack edge.
  - Ack edge: bus_req_o=0, state IDLE, wb_valid_o=1.
- Load result on ack:
  - bus_rdata_i shifted right by off*8.
  - Then sign- or zero-extended to DATA_WIDTH per op; reg_we_o=latched reg_we.
  - Stores: reg_we_o=0.
- bus_err_i with ack: fault_o=1, reg_we_o=0.
- Timeout:
  - Counter counts BUSY cycles without ack; cleared on entry to BUSY.
  - Reaching TIMEOUT: bus_req_o=0, state IDLE, fault_o=1, wb_valid_o=1, reg_we_o=0, stall released in that cycle.
- Ack and timeout on the same cycle: ack wins.
- Back-to-back ops: the instruction presented in the cycle after the ack edge is handled from IDLE normally; no bubble is required.
- misalign_o/fault_o are one-cycle pulses; both are never 1 together.

Decomposition:
- Shared defines header: mem op codes (including LWU/LD/SD), FSM state encoding, ZERO/WRITE_DISABLE constants, and an alignment-check macro.
- Sub-module mem_load_align (combinational):
  - Inputs: rdata, offset, op.
  - Output: shifted, extended value.
  - Parametrised by DATA_WIDTH; reusable by a later cache.

Test Plan:
1. Each case below uses DATA_WIDTH=32.
   - SB addr=0x1003, data=0xAB, ack after 2 wait cycles → bus_addr_o=0x1000, be=4'b1000, wdata[31:24]=0xAB; stall_o high for 3 cycles; wb_valid_o with reg_we_o=0.
2. LB addr=0x2001, rdata=0x0000_8000 → reg_wdata_o=0xFFFF_FF80. LBU same → 0x0000_0080. LHU addr=0x2002, rdata=0xBEEF_0000 → 0x0000_BEEF.
3. LW addr=0x3002 → misalign_o pulse, bus_req_o never asserted, stall_o=0, reg_we_o=0.
4. LW with TIMEOUT=4, no ack → bus_req_o high 4 cycles, then fault_o pulse, stall_o released. Repeat with ack+bus_err_i → fault_o, reg_we_o=0.
5. ADD result 0x1234 to x5, then LW immediately after → ADD writes back the next cycle; LW stalls correctly. rst_i asserted mid-BUSY → bus_req_o falls asynchronously; all outputs 0.
6. DATA_WIDTH=64: LWU addr=0x4004, rdata=0x8765_4321_0000_0000 → 0x0000_0000_8765_4321. SD → be=8'hFF.
